mem_initiator: RTL and testbench
================================

Name: mem_initiator

Overview:
- Bus-master side of the unified instruction/data RAM port. It arbitrates between an instruction-fetch client and a load/store client, then drives the single Read/Write/Address/DataIn strobe set into the RAM and captures the RAM's DataOut.
- The RAM acts on the falling clock edge, so each access is one strobe cycle followed by a registered capture.
- Sits between the CPU core's fetch/LSU stages and the RAM.

Parameters:
- ADDR_W, 16, width of every address bus
- DATA_W, 32, width of every data bus
- DEPTH, 512, number of valid RAM words; an address >= DEPTH is a fault

Ports:
- Clock  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- IReq  in  1  fetch request; held high until IDone is seen
- IAddr  in  ADDR_W  fetch word address; stable while IReq is high
- IRData  out  DATA_W  fetched instruction word
- IDone  out  1  one-cycle completion pulse for fetch
- IFault  out  1  fetch address out of range; valid with IDone
- DReq  in  1  load/store request; held high until DDone is seen
- DWe  in  1  1 = store, 0 = load; stable while DReq is high
- DAddr  in  ADDR_W  data word address
- DWData  in  DATA_W  store data
- DRData  out  DATA_W  load result
- DDone  out  1  one-cycle completion pulse for data
- DFault  out  1  data address out of range; valid with DDone
- MemRead  out  1  RAM read strobe
- MemWrite  out  1  RAM write strobe
- MemAddress  out  ADDR_W  RAM address
- MemWData  out  DATA_W  to RAM DataIn
- MemRData  in  DATA_W  from RAM DataOut; updated on the falling edge
- Busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset and clock: one clock (Clock); Reset is synchronous and active-high.
- Reset values: all outputs are 0, state = IDLE, LastGrant = FETCH (so data wins the first contention).
- All outputs are registered.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the port not recorded in LastGrant (round-robin). Record the grant in LastGrant.
  - In-range grant: at the same edge, register MemAddress = granted address and set MemRead = 1 (fetch, or data with DWe = 0) or MemWrite = 1 (data with DWe = 1). For a store, MemWData = DWData. Go to ACCESS.
  - Out-of-range grant (addr >= DEPTH): no strobe is asserted. Go straight to DONE with the granted Fault = 1 and RData = 0.
- ACCESS (exactly one cycle; the RAM performs the access on the falling edge inside it):
  - At the next rising edge: MemRead and MemWrite go to 0.
  - On a read, the granted RData captures MemRData. On a write, RData is unchanged.
  - Go to DONE.
- DONE (exactly one cycle): the granted Done = 1. Fault is 1 only for a faulted access. Next state is IDLE, and Done and Fault return to 0.
- Client rule: the client samples Done = 1 and drops Req in the same edge's update, so IDLE never re-grants a completed request.
- Strobe and output guarantees:
  - MemRead and MemWrite are never high together and never high for more than one cycle.
  - MemAddress and MemWData hold their values until the next grant.
  - IRData and DRData hold until the next completion on their own port.
- Latency:
  - In-range access: request sampled at edge N; strobe high N..N+1; Done high N+2..N+3; port free at edge N+3.
  - Faulted access: Done high N+1..N+2.
  - Back-to-back throughput is 1 access per 3 cycles.
- Request changes mid-access are ignored. A request dropped before its Done still completes (Done still pulses).
- Reset mid-operation: at the reset edge the strobes drop, the pending Done is discarded (not issued), and the state goes to IDLE. If the RAM write has already occurred it is not undone.

Test Plan:
- Reset then DReq=1, DWe=1, DAddr=0x0005, DWData=0xDEADBEEF -> one-cycle MemWrite at address 0x0005, DDone pulse 2 cycles after the grant, DFault=0, MemRead never high.
- Load back DAddr=0x0005 -> MemRead for one cycle, DRData=0xDEADBEEF with DDone.
- Fetch IAddr=0x0000 (RAM preloaded with 0x08800002) -> IRData=0x08800002, IDone=1, IFault=0.
- IReq and DReq asserted together for 4 transactions -> grant order D, I, D, I; each Done pulses exactly once; Busy stays high between accesses except in IDLE.
- DAddr=0x0200 (512) load -> no MemRead/MemWrite, DDone one cycle after the grant, DFault=1, DRData=0.
- Reset asserted in the ACCESS cycle of a load -> no DDone, all outputs 0 next cycle, a subsequent IReq is served normally.

Source files
------------

// File: rtl/mem_initiator_if.sv
// Bundle of the fetch client, load/store client and RAM strobe signals
// that meet at the mem_initiator.
//
// Handshake: a client raises its Req with a stable address (and DWe/DWData)
// and holds it until its Done pulses for one cycle; Fault and RData are valid
// in that Done cycle. The client drops Req in the same update in which it
// sees Done. MemRead/MemWrite are single-cycle strobes, never both high.
// MemRData is updated by the RAM on the falling edge inside the strobe cycle.
interface mem_initiator_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    // Fetch client
    logic              IReq;
    logic [ADDR_W-1:0] IAddr;
    logic [DATA_W-1:0] IRData;
    logic              IDone;
    logic              IFault;
    // Load/store client
    logic              DReq;
    logic              DWe;
    logic [ADDR_W-1:0] DAddr;
    logic [DATA_W-1:0] DWData;
    logic [DATA_W-1:0] DRData;
    logic              DDone;
    logic              DFault;
    // RAM port
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] MemAddress;
    logic [DATA_W-1:0] MemWData;
    logic [DATA_W-1:0] MemRData;

    // Initiator side
    modport master (
        input  IReq, IAddr,
        output IRData, IDone, IFault,
        input  DReq, DWe, DAddr, DWData,
        output DRData, DDone, DFault,
        output MemRead, MemWrite, MemAddress, MemWData,
        input  MemRData
    );

    // Clients and RAM side
    modport slave (
        output IReq, IAddr,
        input  IRData, IDone, IFault,
        output DReq, DWe, DAddr, DWData,
        input  DRData, DDone, DFault,
        input  MemRead, MemWrite, MemAddress, MemWData,
        output MemRData
    );
endinterface

// File: rtl/mem_initiator.sv
// Bus master for the shared instruction/data RAM port. Round-robin
// arbitration between fetch and load/store, one strobe cycle per access,
// registered capture of RAM read data, out-of-range addresses fault.
module mem_initiator #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512
) (
    input  logic              Clock,
    input  logic              Reset,
    mem_initiator_if.master   bus,
    output logic              Busy,
    output logic [1:0]        StateDbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic              last_data_q, last_data_d;   // 1 = last grant went to data
    logic              gnt_data_q, gnt_data_d;     // port owning the current access
    logic              gnt_read_q, gnt_read_d;
    logic              gnt_fault_q, gnt_fault_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic              i_fault_q, i_fault_d;
    logic              d_fault_q, d_fault_d;
    logic              busy_q, busy_d;

    // Grant decode. Done is registered one cycle after the DONE state, so the
    // client's Req is still high in the IDLE cycle that shows Done; masking
    // that port keeps a finished request from being granted a second time.
    logic              i_req_eff;
    logic              d_req_eff;
    logic              grant_any;
    logic              pick_data;
    logic [ADDR_W-1:0] gnt_addr;
    logic              gnt_oob;
    logic              gnt_store;

    assign i_req_eff = bus.IReq & ~i_done_q;
    assign d_req_eff = bus.DReq & ~d_done_q;
    assign grant_any = i_req_eff | d_req_eff;
    assign pick_data = d_req_eff & (~i_req_eff | ~last_data_q);
    assign gnt_addr  = pick_data ? bus.DAddr : bus.IAddr;
    assign gnt_oob   = ({1'b0, gnt_addr} >= DEPTH_W);
    assign gnt_store = pick_data & bus.DWe;

    // State register and all output/bookkeeping flops
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            last_data_q <= 1'b0;
            gnt_data_q  <= 1'b0;
            gnt_read_q  <= 1'b0;
            gnt_fault_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_fault_q   <= 1'b0;
            d_fault_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            gnt_data_q  <= gnt_data_d;
            gnt_read_q  <= gnt_read_d;
            gnt_fault_q <= gnt_fault_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            i_fault_q   <= i_fault_d;
            d_fault_q   <= d_fault_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state: a faulted grant skips the RAM access entirely
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    state_d = gnt_oob ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs: strobes at grant, capture after the strobe cycle, Done after DONE
    always_comb begin
        last_data_d = last_data_q;
        gnt_data_d  = gnt_data_q;
        gnt_read_d  = gnt_read_q;
        gnt_fault_d = gnt_fault_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        i_fault_d   = 1'b0;
        d_fault_d   = 1'b0;
        busy_d      = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    last_data_d = pick_data;
                    gnt_data_d  = pick_data;
                    gnt_read_d  = ~gnt_store;
                    gnt_fault_d = gnt_oob;
                    if (!gnt_oob) begin
                        mem_addr_d  = gnt_addr;
                        mem_read_d  = ~gnt_store;
                        mem_write_d = gnt_store;
                        if (gnt_store) begin
                            mem_wdata_d = bus.DWData;
                        end
                    end
                end
            end
            S_ACCESS: begin
                // RAM updated MemRData on the falling edge of this cycle
                if (gnt_read_q) begin
                    if (gnt_data_q) begin
                        d_rdata_d = bus.MemRData;
                    end else begin
                        i_rdata_d = bus.MemRData;
                    end
                end
            end
            S_DONE: begin
                if (gnt_data_q) begin
                    d_done_d  = 1'b1;
                    d_fault_d = gnt_fault_q;
                    if (gnt_fault_q) begin
                        d_rdata_d = '0;
                    end
                end else begin
                    i_done_d  = 1'b1;
                    i_fault_d = gnt_fault_q;
                    if (gnt_fault_q) begin
                        i_rdata_d = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.MemRead    = mem_read_q;
    assign bus.MemWrite   = mem_write_q;
    assign bus.MemAddress = mem_addr_q;
    assign bus.MemWData   = mem_wdata_q;
    assign bus.IRData     = i_rdata_q;
    assign bus.IDone      = i_done_q;
    assign bus.IFault     = i_fault_q;
    assign bus.DRData     = d_rdata_q;
    assign bus.DDone      = d_done_q;
    assign bus.DFault     = d_fault_q;
    assign Busy           = busy_q;
    assign StateDbg       = state_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator with a falling-edge RAM model.
module tb_mem_initiator;

    logic        Clock;
    logic        Reset;
    logic        Busy;
    logic [1:0]  StateDbg;
    int          vectors;
    int          miscompares;
    logic [31:0] ram [0:511];
    logic [0:0]  exp_q[$];
    int          rd_cnt;
    int          wr_cnt;
    logic        strobe_both;
    logic        strobe_long;
    logic        prev_strobe;

    mem_initiator_if bus ();

    mem_initiator dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .bus      (bus),
        .Busy     (Busy),
        .StateDbg (StateDbg)
    );

    // Clock / reset block
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // RAM acts on the falling edge
    always @(negedge Clock) begin
        if (bus.MemWrite) ram[bus.MemAddress[8:0]] <= bus.MemWData;
        if (bus.MemRead)  bus.MemRData <= ram[bus.MemAddress[8:0]];
    end

    // Strobe rule monitor
    always @(negedge Clock) begin
        if (bus.MemRead) rd_cnt <= rd_cnt + 1;
        if (bus.MemWrite) wr_cnt <= wr_cnt + 1;
        if (bus.MemRead && bus.MemWrite) strobe_both <= 1'b1;
        if ((bus.MemRead || bus.MemWrite) && prev_strobe) strobe_long <= 1'b1;
        prev_strobe <= bus.MemRead || bus.MemWrite;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        vectors++; if (bus.MemRead !== 1'b0) begin miscompares++; $display("FAIL reset_memread got %b want 0", bus.MemRead); end
        vectors++; if (bus.MemWrite !== 1'b0) begin miscompares++; $display("FAIL reset_memwrite got %b want 0", bus.MemWrite); end
        vectors++; if (bus.MemAddress !== 16'h0) begin miscompares++; $display("FAIL reset_memaddr got %h want 0", bus.MemAddress); end
        vectors++; if ({bus.IDone, bus.DDone, bus.IFault, bus.DFault} !== 4'b0) begin miscompares++; $display("FAIL reset_done_fault got %b want 0000", {bus.IDone, bus.DDone, bus.IFault, bus.DFault}); end
        vectors++; if (bus.IRData !== 32'h0 || bus.DRData !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h/%h want 0/0", bus.IRData, bus.DRData); end
        vectors++; if (Busy !== 1'b0 || StateDbg !== 2'd0) begin miscompares++; $display("FAIL reset_busy_state got %b/%0d want 0/0", Busy, StateDbg); end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_store();
        int rd0;
        rd0 = rd_cnt;
        bus.DWe = 1'b1; bus.DAddr = 16'h0005; bus.DWData = 32'hDEADBEEF; bus.DReq = 1'b1;
        tick(); // grant edge
        vectors++; if (bus.MemWrite !== 1'b1 || bus.MemRead !== 1'b0) begin miscompares++; $display("FAIL store_strobe got wr=%b rd=%b want 1/0", bus.MemWrite, bus.MemRead); end
        vectors++; if (bus.MemAddress !== 16'h0005 || bus.MemWData !== 32'hDEADBEEF) begin miscompares++; $display("FAIL store_bus got %h/%h want 0005/deadbeef", bus.MemAddress, bus.MemWData); end
        vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL store_busy got %b want 1", Busy); end
        tick();
        vectors++; if (bus.MemWrite !== 1'b0 || bus.DDone !== 1'b0) begin miscompares++; $display("FAIL store_access got wr=%b done=%b want 0/0", bus.MemWrite, bus.DDone); end
        tick();
        vectors++; if (bus.DDone !== 1'b1 || bus.DFault !== 1'b0) begin miscompares++; $display("FAIL store_done got done=%b fault=%b want 1/0", bus.DDone, bus.DFault); end
        bus.DReq = 1'b0;
        tick();
        vectors++; if (bus.DDone !== 1'b0 || Busy !== 1'b0) begin miscompares++; $display("FAIL store_after got done=%b busy=%b want 0/0", bus.DDone, Busy); end
        vectors++; if (ram[5] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL store_ram got %h want deadbeef", ram[5]); end
        vectors++; if (rd_cnt !== rd0) begin miscompares++; $display("FAIL store_no_read got %0d reads want %0d", rd_cnt, rd0); end
    endtask

    task automatic test_load();
        bus.DWe = 1'b0; bus.DAddr = 16'h0005; bus.DWData = 32'h0; bus.DReq = 1'b1;
        tick();
        vectors++; if (bus.MemRead !== 1'b1 || bus.MemWrite !== 1'b0 || bus.MemAddress !== 16'h0005) begin miscompares++; $display("FAIL load_strobe got rd=%b wr=%b a=%h want 1/0/0005", bus.MemRead, bus.MemWrite, bus.MemAddress); end
        tick();
        vectors++; if (bus.MemRead !== 1'b0) begin miscompares++; $display("FAIL load_strobe_len got %b want 0", bus.MemRead); end
        tick();
        vectors++; if (bus.DDone !== 1'b1 || bus.DRData !== 32'hDEADBEEF) begin miscompares++; $display("FAIL load_data got done=%b d=%h want 1/deadbeef", bus.DDone, bus.DRData); end
        bus.DReq = 1'b0;
        tick();
    endtask

    task automatic test_fault();
        bus.DWe = 1'b0; bus.DAddr = 16'h0200; bus.DReq = 1'b1;
        tick();
        vectors++; if (bus.MemRead !== 1'b0 || bus.MemWrite !== 1'b0 || bus.DDone !== 1'b0) begin miscompares++; $display("FAIL fault_nostrobe got rd=%b wr=%b done=%b want 0/0/0", bus.MemRead, bus.MemWrite, bus.DDone); end
        vectors++; if (bus.MemAddress !== 16'h0005) begin miscompares++; $display("FAIL fault_addr_hold got %h want 0005", bus.MemAddress); end
        tick();
        vectors++; if (bus.DDone !== 1'b1 || bus.DFault !== 1'b1 || bus.DRData !== 32'h0) begin miscompares++; $display("FAIL fault_done got done=%b fault=%b d=%h want 1/1/0", bus.DDone, bus.DFault, bus.DRData); end
        bus.DReq = 1'b0;
        tick();
        vectors++; if (bus.DDone !== 1'b0 || bus.DFault !== 1'b0 || Busy !== 1'b0) begin miscompares++; $display("FAIL fault_after got done=%b fault=%b busy=%b want 0/0/0", bus.DDone, bus.DFault, Busy); end
    endtask

    task automatic test_fetch();
        bus.IAddr = 16'h0000; bus.IReq = 1'b1;
        tick();
        vectors++; if (bus.MemRead !== 1'b1 || bus.MemAddress !== 16'h0000) begin miscompares++; $display("FAIL fetch_strobe got rd=%b a=%h want 1/0000", bus.MemRead, bus.MemAddress); end
        tick();
        tick();
        vectors++; if (bus.IDone !== 1'b1 || bus.IFault !== 1'b0 || bus.IRData !== 32'h08800002) begin miscompares++; $display("FAIL fetch_data got done=%b fault=%b d=%h want 1/0/08800002", bus.IDone, bus.IFault, bus.IRData); end
        vectors++; if (bus.DRData !== 32'h0) begin miscompares++; $display("FAIL fetch_drdata_hold got %h want 0", bus.DRData); end
        bus.IReq = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int seen;
        int cycles;
        logic [0:0] got;
        exp_q = {1'b1, 1'b0, 1'b1, 1'b0}; // 1 = data, 0 = fetch
        seen = 0;
        cycles = 0;
        bus.IAddr = 16'h0001; bus.DAddr = 16'h0002; bus.DWe = 1'b0;
        bus.IReq = 1'b1; bus.DReq = 1'b1;
        while (seen < 4 && cycles < 40) begin
            tick();
            cycles++;
            if (bus.IDone || bus.DDone) begin
                seen++;
                got = bus.DDone;
                vectors++; if (exp_q.size() == 0 || got !== exp_q[0] || (bus.IDone && bus.DDone)) begin miscompares++; $display("FAIL b2b_order done %0d got port %b want %b", seen, got, (exp_q.size() != 0) ? exp_q[0] : 1'bx); end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_idle got %b want 0", Busy); end
            end else begin
                vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy_active cycle %0d got %b want 1", cycles, Busy); end
            end
        end
        bus.IReq = 1'b0; bus.DReq = 1'b0;
        vectors++; if (seen !== 4 || cycles !== 12) begin miscompares++; $display("FAIL b2b_throughput got %0d dones in %0d cycles want 4 in 12", seen, cycles); end
        vectors++; if (bus.IRData !== 32'h10000001 || bus.DRData !== 32'h10000002) begin miscompares++; $display("FAIL b2b_data got %h/%h want 10000001/10000002", bus.IRData, bus.DRData); end
        tick();
        tick();
        vectors++; if (Busy !== 1'b0 || bus.IDone !== 1'b0 || bus.DDone !== 1'b0) begin miscompares++; $display("FAIL b2b_quiet got busy=%b i=%b d=%b want 0/0/0", Busy, bus.IDone, bus.DDone); end
    endtask

    task automatic test_reset_mid();
        int d_seen;
        d_seen = 0;
        bus.DWe = 1'b0; bus.DAddr = 16'h0005; bus.DReq = 1'b1;
        tick();
        vectors++; if (bus.MemRead !== 1'b1 || StateDbg !== 2'd1) begin miscompares++; $display("FAIL rmid_access got rd=%b st=%0d want 1/1", bus.MemRead, StateDbg); end
        Reset = 1'b1; bus.DReq = 1'b0;
        tick();
        vectors++; if (bus.MemRead !== 1'b0 || Busy !== 1'b0 || StateDbg !== 2'd0) begin miscompares++; $display("FAIL rmid_clear got rd=%b busy=%b st=%0d want 0/0/0", bus.MemRead, Busy, StateDbg); end
        vectors++; if (bus.DRData !== 32'h0 || bus.IRData !== 32'h0 || bus.MemAddress !== 16'h0) begin miscompares++; $display("FAIL rmid_zero got %h/%h/%h want 0/0/0", bus.DRData, bus.IRData, bus.MemAddress); end
        Reset = 1'b0;
        repeat (4) begin
            tick();
            if (bus.DDone) d_seen++;
        end
        vectors++; if (d_seen !== 0) begin miscompares++; $display("FAIL rmid_no_done got %0d want 0", d_seen); end
        bus.IAddr = 16'h0003; bus.IReq = 1'b1;
        tick();
        vectors++; if (bus.MemRead !== 1'b1 || bus.MemAddress !== 16'h0003) begin miscompares++; $display("FAIL rmid_fetch_strobe got rd=%b a=%h want 1/0003", bus.MemRead, bus.MemAddress); end
        tick();
        tick();
        vectors++; if (bus.IDone !== 1'b1 || bus.IRData !== 32'h10000003) begin miscompares++; $display("FAIL rmid_fetch got done=%b d=%h want 1/10000003", bus.IDone, bus.IRData); end
        bus.IReq = 1'b0;
        tick();
    endtask

    task automatic test_strobe_rules();
        vectors++; if (strobe_both !== 1'b0) begin miscompares++; $display("FAIL strobe_both got %b want 0", strobe_both); end
        vectors++; if (strobe_long !== 1'b0) begin miscompares++; $display("FAIL strobe_long got %b want 0", strobe_long); end
        vectors++; if (wr_cnt !== 1) begin miscompares++; $display("FAIL strobe_writes got %0d want 1", wr_cnt); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rd_cnt = 0;
        wr_cnt = 0;
        strobe_both = 1'b0;
        strobe_long = 1'b0;
        prev_strobe = 1'b0;
        for (int i = 0; i < 512; i++) ram[i] = 32'h10000000 + i;
        ram[0] = 32'h08800002;
        Reset = 1'b1;
        bus.IReq = 1'b0; bus.IAddr = '0;
        bus.DReq = 1'b0; bus.DWe = 1'b0; bus.DAddr = '0; bus.DWData = '0;
        bus.MemRData = '0;
        test_reset();
        test_store();
        test_load();
        test_fault();
        test_fetch();
        test_back_to_back();
        test_reset_mid();
        test_strobe_rules();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
